controle_catraca: RTL and testbench

Access controller for a single shared turnstile used in both directions. Arbitrates between entry and exit requesters, unlocks the turnstile in the granted direction, and counts a passage on a completed rotation (`giro`). Aborts an entry on metal detection, aborts on a rotation timeout, and tracks occupancy against a fixed capacity. Sits between the request switches/sensors and the turnstile lock drivers and status LEDs.

---
 rtl/controle_catraca.sv | 112 +++++++++++
 tb/tb_controle_catraca.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/controle_catraca.sv
// Bidirectional turnstile controller: arbitrates entry/exit requests, unlocks one
// direction at a time, counts completed rotations and tracks occupancy.
module controle_catraca #(
  parameter int CAPACIDADE = 15,
  parameter int LARG_OCUP  = 4,
  parameter int TIMEOUT    = 50
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pedido_entrada,
  input  logic                 pedido_saida,
  input  logic                 metais,
  input  logic                 giro,
  output logic                 libera_entrada,
  output logic                 libera_saida,
  output logic                 alarme,
  output logic                 lotado,
  output logic [LARG_OCUP-1:0] ocupacao,
  output logic [4:0]           estadoLed
);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ENTRADA = 2'd1,
    SAIDA   = 2'd2,
    ALARME  = 2'd3
  } estado_t;

  localparam logic [LARG_OCUP-1:0] CAP_MAX   = LARG_OCUP'(CAPACIDADE);
  localparam logic [7:0]           TIMER_MAX = 8'(TIMEOUT - 1);
  localparam logic [LARG_OCUP-1:0] UM        = LARG_OCUP'(1);

  estado_t    estado;
  logic [7:0] timer;
  logic       giro_q;
  logic       ultimo;  // last direction served: 0 = entrada, 1 = saida
  logic       giro_ev;
  logic       el_e;
  logic       el_s;

  assign giro_ev = giro & ~giro_q;
  assign lotado  = (ocupacao == CAP_MAX);
  assign el_e    = pedido_entrada & ~lotado;
  assign el_s    = pedido_saida & (ocupacao != '0);

  assign libera_entrada = (estado == ENTRADA);
  assign libera_saida   = (estado == SAIDA);
  assign alarme         = (estado == ALARME);
  assign estadoLed      = {estado == OCIOSO, estado == ENTRADA, estado == SAIDA,
                           estado == ALARME, lotado};

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= OCIOSO;
      ocupacao <= '0;
      timer    <= '0;
      giro_q   <= 1'b0;
      ultimo   <= 1'b1;
    end else begin
      giro_q <= giro;
      case (estado)
        OCIOSO: begin
          // A rotation seen while idle is forced and deliberately not counted.
          if (pedido_entrada && metais) begin
            estado <= ALARME;
          end else if (el_e && el_s) begin
            estado <= ultimo ? ENTRADA : SAIDA;
            timer  <= '0;
          end else if (el_e) begin
            estado <= ENTRADA;
            timer  <= '0;
          end else if (el_s) begin
            estado <= SAIDA;
            timer  <= '0;
          end
        end
        ENTRADA: begin
          if (metais) begin
            estado <= ALARME;
            ultimo <= 1'b0;
          end else if (giro_ev) begin
            ocupacao <= ocupacao + UM;
            ultimo   <= 1'b0;
            estado   <= OCIOSO;
          end else if (timer == TIMER_MAX) begin
            ultimo <= 1'b0;
            estado <= OCIOSO;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        SAIDA: begin
          if (giro_ev) begin
            ocupacao <= ocupacao - UM;
            ultimo   <= 1'b1;
            estado   <= OCIOSO;
          end else if (timer == TIMER_MAX) begin
            ultimo <= 1'b1;
            estado <= OCIOSO;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        ALARME: begin
          if (!metais && !pedido_entrada) estado <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_catraca.sv
// Table-driven bench for controle_catraca (capacity 3, timeout 8) with a few
// hand-written multi-cycle sequences for timeout width and re-grant behaviour.
module tb_controle_catraca;

  localparam int CAP = 3;
  localparam int LO  = 4;
  localparam int TO  = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          pedido_entrada;
  logic          pedido_saida;
  logic          metais;
  logic          giro;
  logic          libera_entrada;
  logic          libera_saida;
  logic          alarme;
  logic          lotado;
  logic [LO-1:0] ocupacao;
  logic [4:0]    estadoLed;

  controle_catraca #(
    .CAPACIDADE(CAP),
    .LARG_OCUP (LO),
    .TIMEOUT   (TO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pedido_entrada(pedido_entrada),
    .pedido_saida  (pedido_saida),
    .metais        (metais),
    .giro          (giro),
    .libera_entrada(libera_entrada),
    .libera_saida  (libera_saida),
    .alarme        (alarme),
    .lotado        (lotado),
    .ocupacao      (ocupacao),
    .estadoLed     (estadoLed)
  );

  // clock/reset block
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        pe;
    logic        ps;
    logic        met;
    logic        gi;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [12:0] obs;
  assign obs = {libera_entrada, libera_saida, alarme, lotado, ocupacao, estadoLed};

  // expected word: {libera_entrada, libera_saida, alarme, lotado, ocupacao, estadoLed}
  function automatic void add(input logic r, p, s, m, g, le, ls, al,
                              input logic [3:0] oc, input logic [4:0] led);
    vec_t v;
    v.rst = r; v.pe = p; v.ps = s; v.met = m; v.gi = g;
    v.exp = {le, ls, al, led[0], oc, led};
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, p, s, m, g);
    reset = r; pedido_entrada = p; pedido_saida = s; metais = m; giro = g;
  endtask

  int hi_n;
  int lo_n;

  initial begin
    drive(1, 0, 0, 0, 0);

    // A: single entry, giro three cycles after the request
    add(1,0,0,0,0, 0,0,0,0,5'b10000);
    add(0,1,0,0,0, 1,0,0,0,5'b01000);
    add(0,0,0,0,0, 1,0,0,0,5'b01000);
    add(0,0,0,0,0, 1,0,0,0,5'b01000);
    add(0,0,0,0,1, 0,0,0,1,5'b10000);
    add(0,0,0,0,1, 0,0,0,1,5'b10000);
    add(0,0,0,0,0, 0,0,0,1,5'b10000);
    // B: both requests held, alternation
    add(1,0,0,0,0, 0,0,0,0,5'b10000);
    add(0,1,1,0,0, 1,0,0,0,5'b01000);
    add(0,1,1,0,1, 0,0,0,1,5'b10000);
    add(0,1,1,0,0, 0,1,0,1,5'b00100);
    add(0,1,1,0,1, 0,0,0,0,5'b10000);
    add(0,1,1,0,0, 1,0,0,0,5'b01000);
    add(0,1,1,0,1, 0,0,0,1,5'b10000);
    add(0,1,1,0,0, 0,1,0,1,5'b00100);
    add(0,0,0,0,0, 0,1,0,1,5'b00100);
    add(0,0,0,0,1, 0,0,0,0,5'b10000);
    add(0,0,0,0,0, 0,0,0,0,5'b10000);
    // C: metal alarm from idle, then metal abort mid-entry
    add(0,1,0,1,0, 0,0,1,0,5'b00010);
    add(0,0,0,1,0, 0,0,1,0,5'b00010);
    add(0,1,0,0,0, 0,0,1,0,5'b00010);
    add(0,0,0,0,0, 0,0,0,0,5'b10000);
    add(0,1,0,0,0, 1,0,0,0,5'b01000);
    add(0,0,0,0,0, 1,0,0,0,5'b01000);
    add(0,0,0,1,1, 0,0,1,0,5'b00010);
    add(0,0,0,0,0, 0,0,0,0,5'b10000);
    // D: entry timeout, libera_entrada high exactly 8 cycles
    add(0,1,0,0,0, 1,0,0,0,5'b01000);
    for (int i = 0; i < TO - 1; i++) add(0,0,0,0,0, 1,0,0,0,5'b01000);
    add(0,0,0,0,0, 0,0,0,0,5'b10000);
    // E: giro edge on the last timeout cycle still counts
    add(0,1,0,0,0, 1,0,0,0,5'b01000);
    for (int i = 0; i < TO - 1; i++) add(0,0,0,0,0, 1,0,0,0,5'b01000);
    add(0,0,0,0,1, 0,0,0,1,5'b10000);
    add(0,0,0,0,0, 0,0,0,1,5'b10000);
    // F: fill to capacity, refused entry, alarm outranks exit, exit ignores metal
    add(0,1,0,0,0, 1,0,0,1,5'b01000);
    add(0,0,0,0,1, 0,0,0,2,5'b10000);
    add(0,1,0,0,0, 1,0,0,2,5'b01000);
    add(0,0,0,0,1, 0,0,0,3,5'b10001);
    add(0,1,0,0,0, 0,0,0,3,5'b10001);
    add(0,1,0,0,0, 0,0,0,3,5'b10001);
    add(0,1,1,1,0, 0,0,1,3,5'b00011);
    add(0,0,0,0,0, 0,0,0,3,5'b10001);
    add(0,0,1,0,0, 0,1,0,3,5'b00101);
    add(0,0,0,1,1, 0,0,0,2,5'b10000);
    add(0,0,0,0,0, 0,0,0,2,5'b10000);
    // G: reset during entry clears occupancy; exit at zero never granted
    add(0,1,0,0,0, 1,0,0,2,5'b01000);
    add(1,0,0,0,0, 0,0,0,0,5'b10000);
    add(0,0,1,0,0, 0,0,0,0,5'b10000);
    add(0,0,1,0,0, 0,0,0,0,5'b10000);
    add(0,0,1,0,0, 0,0,0,0,5'b10000);
    // H: forced rotation while idle; giro already high at grant needs a new edge
    add(0,0,0,0,1, 0,0,0,0,5'b10000);
    add(0,1,0,0,1, 1,0,0,0,5'b01000);
    add(0,0,0,0,1, 1,0,0,0,5'b01000);
    add(0,0,0,0,0, 1,0,0,0,5'b01000);
    add(0,0,0,0,1, 0,0,0,1,5'b10000);
    add(0,0,0,0,0, 0,0,0,1,5'b10000);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].pe, vecs[i].ps, vecs[i].met, vecs[i].gi);
      tick();
      check($sformatf("row%0d", i), 32'(obs), 32'(vecs[i].exp));
    end

    // exit timeout: libera_saida width, occupancy unchanged
    drive(0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    hi_n = 0;
    while (libera_saida && hi_n < 20) begin
      hi_n++;
      tick();
    end
    check("saida_timeout_width", 32'(hi_n), 32'(TO));
    check("saida_timeout_ocup", 32'(ocupacao), 32'd1);

    // held entry request: 8 cycles granted, 1 cycle idle, granted again
    drive(0, 1, 0, 0, 0);
    tick();
    hi_n = 0;
    while (libera_entrada && hi_n < 20) begin
      hi_n++;
      tick();
    end
    lo_n = 0;
    while (!libera_entrada && lo_n < 20) begin
      lo_n++;
      tick();
    end
    check("regrant_high_width", 32'(hi_n), 32'(TO));
    check("regrant_idle_gap", 32'(lo_n), 32'd1);
    drive(0, 0, 0, 0, 0);
    hi_n = 0;
    while (libera_entrada && hi_n < 20) begin
      hi_n++;
      tick();
    end
    check("regrant_second_width", 32'(hi_n), 32'(TO));
    check("final_led", 32'(estadoLed), 32'(5'b10000));
    check("final_ocup", 32'(ocupacao), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
